// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed seven-segment scan driver with per-frame latching
module seg7_scan #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_start
);

  // Prescaler width; guarded so a degenerate DIV still yields a legal vector.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Scan state
  logic [PW-1:0] p_q, p_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   lv_q, lv_d;
  logic [3:0]    ldp_q, ldp_d;
  // Set on the 3 -> 0 wrap, consumed by the first enabled output cycle of the frame.
  logic          wrap_q, wrap_d;

  // Output registers
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_n_q, dp_n_d;
  logic       fs_q, fs_d;

  logic       tick;
  logic       frame_end;
  logic [3:0] nib;
  logic       blank;

  // Hex digit to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hexfont(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick      = en & (p_q == P_LAST);
  assign frame_end = tick & (idx_q == 2'd3);

  // Next-state for prescaler, digit index and the frame latch.
  always_comb begin
    p_d    = p_q;
    idx_d  = idx_q;
    lv_d   = lv_q;
    ldp_d  = ldp_q;
    wrap_d = wrap_q;
    if (tick) begin
      p_d   = '0;
      idx_d = idx_q + 2'd1;
    end else if (en) begin
      p_d = p_q + 1'b1;
    end
    if (frame_end) begin
      lv_d   = value;
      ldp_d  = dp;
      wrap_d = 1'b1;
    end else if (en) begin
      wrap_d = 1'b0;
    end
  end

  // Current nibble and leading-zero blanking for the digit being scanned.
  always_comb begin
    nib = lv_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd1:    blank = (lv_q[15:4] == 12'h000);
      2'd2:    blank = (lv_q[15:8] == 8'h00);
      2'd3:    blank = (lv_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    blank = blank & blank_lz;
  end

  // Output decode: dark when disabled, otherwise the selected digit.
  always_comb begin
    an_d   = AN_OFF;
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    fs_d   = 1'b0;
    if (en) begin
      an_d   = ~(4'b0001 << idx_q);
      seg_d  = blank ? SEG_OFF : hexfont(nib);
      dp_n_d = ~ldp_q[idx_q];
      fs_d   = wrap_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      idx_q  <= 2'd0;
      lv_q   <= 16'h0000;
      ldp_q  <= 4'h0;
      wrap_q <= 1'b0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_n_q <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      p_q    <= p_d;
      idx_q  <= idx_d;
      lv_q   <= lv_d;
      ldp_q  <= ldp_d;
      wrap_q <= wrap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
      fs_q   <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized and directed check of seg7_scan against a cycle-count model
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst, en, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n, frame_start;

  seg7_scan #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .value(value), .dp(dp), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp_n(dp_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: ec counts enabled cycles since reset; digit = (ec/DIV) mod 4.
  int          ec;
  logic [15:0] m_lv;
  logic [3:0]  m_ldp;
  logic [6:0]  font [16];
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dpn, e_fs;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int d;
    logic [15:0] upper;
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fs = 1'b0;
      ec = 0; m_lv = 16'h0; m_ldp = 4'h0;
    end else if (!en) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fs = 1'b0;
    end else begin
      d = (ec / DIV) % 4;
      upper = m_lv >> (4 * d);
      e_an  = ~(4'(1) << d);
      e_seg = (blank_lz && d > 0 && upper == 16'h0) ? 7'h7F : font[upper[3:0]];
      e_dpn = ~m_ldp[d];
      e_fs  = (ec > 0) && (ec % FRAME == 0);
      if (ec % FRAME == FRAME - 1) begin
        m_lv  = value;
        m_ldp = dp;
      end
      ec++;
    end
    @(posedge clk);
    #1;
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp_n", 16'(dp_n), 16'(e_dpn));
    chk("frame_start", 16'(frame_start), 16'(e_fs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_digit(input int d);
    int guard;
    guard = 0;
    while (((ec / DIV) % 4) != d && guard < 4 * FRAME) begin
      step();
      guard++;
    end
    chk("wait_digit_bound", 16'(guard < 4 * FRAME), 16'd1);
  endtask

  logic [15:0] sweep [4];
  logic [15:0] masks [5];

  initial begin
    font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    sweep = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    ec = 0; m_lv = 0; m_ldp = 0;

    // Reset state
    rst = 1'b1; en = 1'b1; value = 16'h1234; dp = 4'h0; blank_lz = 1'b0;
    run(3);
    chk("reset_an", 16'(an), 16'hF);
    chk("reset_seg", 16'(seg), 16'h7F);

    // Release: one frame of 0, then 1234 with frame_start on digit 0 entry
    rst = 1'b0;
    step();
    chk("first_an", 16'(an), 16'b1110);
    chk("first_seg", 16'(seg), 16'h40);
    run(FRAME - 1);
    step();
    chk("f1_an", 16'(an), 16'b1110);
    chk("f1_seg", 16'(seg), 16'h19);
    chk("f1_fs", 16'(frame_start), 16'd1);
    run(DIV - 1);
    step();
    chk("f1_d1_an", 16'(an), 16'b1101);
    chk("f1_d1_seg", 16'(seg), 16'h30);
    run(3 * FRAME);

    // Font sweep
    for (int k = 0; k < 4; k++) begin
      value = sweep[k];
      run(2 * FRAME);
    end

    // Leading zeros
    blank_lz = 1'b1; value = 16'h0005;
    run(2 * FRAME);
    wait_digit(3);
    step();
    chk("lz_d3_seg", 16'(seg), 16'h7F);
    chk("lz_d3_an", 16'(an), 16'b0111);
    value = 16'h0000;
    run(2 * FRAME);
    blank_lz = 1'b0;
    run(FRAME);

    // Tearing: change value while digit 1 is on screen
    value = 16'h1111;
    run(2 * FRAME);
    wait_digit(1);
    value = 16'h2222;
    wait_digit(2);
    step();
    chk("tear_d2_seg", 16'(seg), 16'h79);
    run(2 * FRAME);

    // dp and en drop mid-slot
    dp = 4'b0100;
    run(2 * FRAME);
    wait_digit(2);
    step();
    chk("dp_d2", 16'(dp_n), 16'd0);
    en = 1'b0;
    step();
    chk("en_off_an", 16'(an), 16'hF);
    run(9);
    en = 1'b1;
    run(2 * FRAME);

    // Reset mid-frame
    wait_digit(2);
    rst = 1'b1;
    step();
    chk("midrst_an", 16'(an), 16'hF);
    chk("midrst_dpn", 16'(dp_n), 16'd1);
    rst = 1'b0;
    step();
    chk("post_rst_an", 16'(an), 16'b1110);
    chk("post_rst_seg", 16'(seg), 16'h40);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        value = 16'($urandom) & masks[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
